// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: registered N-way arbiter with a fixed-priority or
// round-robin mode chosen at elaboration and a per-owner lock with a
// bounded hold limit.
//
// The winner search has no variable bit indexing. The request vector is
// rotated right by ptr, so the highest-priority requester lands in bit 0.
// A prefix-OR chain then isolates the first set bit. That one-hot is
// rotated back left by ptr to give the grant in the original bit order.
// Fixed-priority mode is the same datapath with ptr held at 0.
module rr_lock_arbiter #(
    parameter int N        = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 4,
    parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    // The hold counter only needs to reach MAX_HOLD-1.
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 1) ? (MAX_HOLD - 1) : 0);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

    logic [N-1:0]   gnt_q, gnt_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

    logic [N-1:0]   rot_req;          // req rotated so that ptr sits at bit 0
    logic [N:0]     seen;             // prefix OR of rot_req
    logic [N-1:0]   rot_oh;           // first requester, in the rotated frame
    logic [N-1:0]   win_gnt;          // winner one-hot, in the original frame
    logic [IDW-1:0] id_acc [N+1];     // running encoder of win_gnt
    logic [IDW-1:0] win_id;
    logic           any_req;
    logic           owner_req;
    logic           owner_lock;
    logic           hold_ok;

    assign rot_req = N'({req, req} >> ptr_q);
    assign seen[0] = 1'b0;
    assign id_acc[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_scan
            assign seen[gi+1]   = seen[gi] | rot_req[gi];
            assign rot_oh[gi]   = rot_req[gi] & ~seen[gi];
            assign id_acc[gi+1] = id_acc[gi] | (win_gnt[gi] ? IDW'(gi) : '0);
        end
    endgenerate

    assign any_req = seen[N];
    assign win_gnt = N'(({rot_oh, rot_oh} << ptr_q) >> N);
    assign win_id  = id_acc[N];

    // The owner's req and lock are picked out by masking with the one-hot grant.
    always_comb begin
        owner_req  = |(req & gnt_q);
        owner_lock = |(lock & gnt_q);
        hold_ok    = gnt_valid_q && owner_req && owner_lock &&
                     ((MAX_HOLD == 0) || (hold_cnt_q < HOLD_LAST));
    end

    // Next-state selection: keep the held grant, arbitrate, or go idle.
    always_comb begin
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        if (hold_ok) begin
            // With no hold limit the counter is never compared, so it stays put.
            if (MAX_HOLD != 0) begin
                hold_cnt_d = hold_cnt_q + HCW'(1);
            end
        end else if (any_req) begin
            gnt_d       = win_gnt;
            gnt_valid_d = 1'b1;
            gnt_id_d    = win_id;
            hold_cnt_d  = '0;
            if (RR_MODE != 0) begin
                ptr_d = (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
            end
        end else begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
            hold_cnt_d  = '0;
        end
    end

    // State register. Reset overrides any hold that is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: drives five arbiter configurations from shared inputs.
// A behavioural model predicts each grant and pushes it into a scoreboard
// queue. A separate monitor pops the prediction after each edge and compares.
module tb_rr_lock_arbiter;

    localparam int NDUT = 5;
    // Configurations: RR N=4 hold 4, fixed N=4, RR unlimited hold, RR N=3 hold 2, N=1 hold 2.
    localparam int CFG_N  [NDUT] = '{4, 4, 4, 3, 1};
    localparam int CFG_RR [NDUT] = '{1, 0, 1, 1, 1};
    localparam int CFG_MH [NDUT] = '{4, 4, 0, 2, 2};

    typedef struct packed {
        logic [3:0] gnt;
        logic       v;
        logic [1:0] id;
    } exp_t;
    typedef exp_t [NDUT-1:0] cyc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] lock = '0;

    logic [3:0] g0, g1, g2;
    logic       v0, v1, v2, v3, v4;
    logic [1:0] i0, i1, i2, i3;
    logic [2:0] g3;
    logic [0:0] g4, i4;

    cyc_t sb[$];
    int   m_owner [NDUT];
    int   m_ptr   [NDUT];
    int   m_hc    [NDUT];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    rr_lock_arbiter #(.N(4), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .gnt(g0), .gnt_valid(v0), .gnt_id(i0));
    rr_lock_arbiter #(.N(4), .RR_MODE(0), .MAX_HOLD(4)) u_fx (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .gnt(g1), .gnt_valid(v1), .gnt_id(i1));
    rr_lock_arbiter #(.N(4), .RR_MODE(1), .MAX_HOLD(0)) u_ul (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .gnt(g2), .gnt_valid(v2), .gnt_id(i2));
    rr_lock_arbiter #(.N(3), .RR_MODE(1), .MAX_HOLD(2)) u_n3 (
        .clk(clk), .rst(rst), .req(req[2:0]), .lock(lock[2:0]),
        .gnt(g3), .gnt_valid(v3), .gnt_id(i3));
    rr_lock_arbiter #(.N(1), .RR_MODE(1), .MAX_HOLD(2)) u_n1 (
        .clk(clk), .rst(rst), .req(req[0:0]), .lock(lock[0:0]),
        .gnt(g4), .gnt_valid(v4), .gnt_id(i4));

    // Reference model: owner index (-1 when idle), priority pointer, and hold count.
    task automatic model_step(input int k, input logic [3:0] r_in,
                              input logic [3:0] l_in, input logic rs);
        int n, w, idx;
        logic [3:0] r;
        n = CFG_N[k];
        r = r_in & 4'((1 << n) - 1);
        if (rs) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_hc[k]    = 0;
        end else if (m_owner[k] >= 0 && r[m_owner[k]] && l_in[m_owner[k]] &&
                     (CFG_MH[k] == 0 || m_hc[k] < CFG_MH[k] - 1)) begin
            m_hc[k] = m_hc[k] + 1;
        end else begin
            w = -1;
            for (int j = 0; j < n; j++) begin
                idx = (CFG_RR[k] != 0) ? (m_ptr[k] + j) % n : j;
                if (w < 0 && r[idx]) w = idx;
            end
            m_owner[k] = w;
            m_hc[k]    = 0;
            if (w >= 0 && CFG_RR[k] != 0) m_ptr[k] = (w + 1) % n;
        end
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.gnt = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'd0;
        e.v   = (m_owner[k] >= 0);
        e.id  = (m_owner[k] >= 0) ? 2'(m_owner[k]) : 2'd0;
        return e;
    endfunction

    // Apply one cycle of inputs and push the predicted response for every configuration.
    task automatic drive(input logic rs, input logic [3:0] r, input logic [3:0] l);
        cyc_t c;
        @(negedge clk);
        rst  = rs;
        req  = r;
        lock = l;
        for (int k = 0; k < NDUT; k++) begin
            model_step(k, r, l, rs);
            c[k] = model_out(k);
        end
        sb.push_back(c);
        $display("cyc %0d rst=%b req=%b lock=%b -> expect rr=%b fx=%b ul=%b n3=%b n1=%b",
                 cyc, rs, r, l, c[0].gnt, c[1].gnt, c[2].gnt, c[3].gnt[2:0], c[4].gnt[0]);
        cyc++;
    endtask

    // Monitor: the outputs are valid every cycle, so each edge consumes one prediction.
    initial begin
        cyc_t e;
        exp_t a [NDUT];
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a[0] = {g0, v0, i0};
                a[1] = {g1, v1, i1};
                a[2] = {g2, v2, i2};
                a[3] = {1'b0, g3, v3, i3};
                a[4] = {3'b000, g4, v4, 1'b0, i4};
                for (int k = 0; k < NDUT; k++) begin
                    n_checks++;
                    if (a[k] === e[k]) begin
                        n_pass++;
                    end else begin
                        $display("FAIL grant dut%0d: got gnt=%b v=%b id=%0d, want gnt=%b v=%b id=%0d",
                                 k, a[k].gnt, a[k].v, a[k].id, e[k].gnt, e[k].v, e[k].id);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] r, l;
        for (int k = 0; k < NDUT; k++) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_hc[k]    = 0;
        end
        // Reset held for two cycles with every requester active.
        repeat (2) drive(1'b1, 4'b1111, 4'b0000);
        // Rotation, and fixed priority on the fixed-mode instance.
        repeat (5) drive(1'b0, 4'b1111, 4'b0000);
        drive(1'b0, 4'b1100, 4'b0000);
        // Lock on requester 1 against the hold limit (unlimited on u_ul).
        drive(1'b1, 4'b1111, 4'b0000);
        repeat (10) drive(1'b0, 4'b1111, 4'b0010);
        drive(1'b0, 4'b1101, 4'b0010);
        // Reset in the middle of a hold.
        drive(1'b1, 4'b0000, 4'b0000);
        repeat (2) drive(1'b0, 4'b1111, 4'b0010);
        drive(1'b1, 4'b1111, 4'b0010);
        repeat (2) drive(1'b0, 4'b1111, 4'b0000);
        // Sole requester, then wrap of the pointer, then idle.
        repeat (3) drive(1'b0, 4'b0100, 4'b0000);
        repeat (2) drive(1'b0, 4'b1001, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        // Sole requester on N=1 hitting its lock limit.
        repeat (4) drive(1'b0, 4'b0001, 4'b0001);
        // Randomised traffic with locks biased high and occasional resets.
        for (int t = 0; t < 400; t++) begin
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = r | 4'($urandom);
            l = 4'($urandom) | 4'($urandom);
            drive($urandom_range(0, 49) == 0, r, l);
        end
        @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending predictions, want 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
